alarm_ringer: RTL

Downstream consumer of the alarm compare stage's ALARM_DOING level. It turns a trigger into a user-facing alarm:
- a cadenced piezo tone and a ring LED;
- snooze with a bounded retry count, and dismiss;
- an auto-timeout.

It owns the alarm's lifetime after the trigger; ALARM_DOING going low does not silence it.

---
 rtl/alarm_ringer_pkg.sv | 23 ++
 rtl/alarm_ringer_sec_prescaler.sv | 41 ++++
 rtl/alarm_ringer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_pkg.sv
// -----------------------------------------------------------------------------
// alarm_ringer_pkg
// Shared definitions for the alarm ringer and its helpers:
//   - 2-bit FSM state encoding (IDLE / RING / SNOOZE)
//   - tone_half(): clock cycles per piezo half-period
//   - cnt_width(): bits needed for a counter running 0..terminal-1
// -----------------------------------------------------------------------------
package alarm_ringer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    function automatic int tone_half(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

    // At least one bit so a terminal of 1 still yields a legal vector.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/alarm_ringer_sec_prescaler.sv
// -----------------------------------------------------------------------------
// sec_prescaler
// Divides the system clock down to a one-cycle pulse once per second.
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       synchronous clear; count restarts at 0 on the next edge
//   o_sec_tick  high during the cycle the count sits at CLK_HZ-1
// -----------------------------------------------------------------------------
module sec_prescaler
    import alarm_ringer_pkg::*;
#(
    parameter int CLK_HZ = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_sec_tick
);

    localparam int CNT_W = cnt_width(CLK_HZ);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_W'(CLK_HZ - 1));
    assign o_sec_tick = w_last;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
// Turns the compare stage's ALARM_DOING trigger into a user-facing alarm:
// cadenced piezo tone with ring LED, bounded snooze, dismiss and auto-timeout.
// Once triggered the alarm owns its own lifetime; ALARM_DOING falling or
// re-rising while active has no effect.
// Ports:
//   CLK, RESETN     clock, asynchronous active-low reset
//   ALARM_DOING     trigger level (rising edge starts ringing from IDLE)
//   KEY_STOP        debounced key; rising edge dismisses
//   KEY_SNOOZE      debounced key; rising edge snoozes while ringing
//   PIEZO           registered tone output
//   RING_LED        high while ringing
//   SNOOZE_ACTIVE   high while snoozing
//   SNOOZE_LEFT     snoozes still available in the current event
// -----------------------------------------------------------------------------
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int CLK_HZ      = 100000,
    parameter int TONE_HZ     = 1000,
    parameter int CADENCE_CYC = 50000,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       ALARM_DOING,
    input  logic       KEY_STOP,
    input  logic       KEY_SNOOZE,
    output logic       PIEZO,
    output logic       RING_LED,
    output logic       SNOOZE_ACTIVE,
    output logic [3:0] SNOOZE_LEFT
);

    localparam int TONE_HALF = tone_half(CLK_HZ, TONE_HZ);
    localparam int MAX_SEC   = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int TONE_W    = cnt_width(TONE_HALF);
    localparam int CAD_W     = cnt_width(CADENCE_CYC);
    localparam int SEC_W     = cnt_width(MAX_SEC);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_alarm_d, r_stop_d, r_snooze_d;
    logic             w_rise_alarm, w_rise_stop, w_rise_snooze;
    logic             w_state_change;
    logic             w_sec_tick;
    logic [SEC_W-1:0] r_sec;
    logic             w_ring_done, w_snooze_done;
    logic [CAD_W-1:0] r_cad_cnt;
    logic             r_cad_on;
    logic [TONE_W-1:0] r_tone_cnt;
    logic             r_piezo, r_ring_led, r_snooze_active;
    logic [3:0]       r_snooze_left;

    assign w_rise_alarm  = ALARM_DOING & ~r_alarm_d;
    assign w_rise_stop   = KEY_STOP    & ~r_stop_d;
    assign w_rise_snooze = KEY_SNOOZE  & ~r_snooze_d;

    // The seconds counter is considered to reach its terminal on the tick that
    // would take it there, so the state changes exactly RING_SEC / SNOOZE_SEC
    // seconds after entry and the counter never has to hold the terminal value.
    assign w_ring_done   = w_sec_tick && (r_sec == SEC_W'(RING_SEC - 1));
    assign w_snooze_done = w_sec_tick && (r_sec == SEC_W'(SNOOZE_SEC - 1));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise_alarm) w_next = ST_RING;
            end
            ST_RING: begin
                if (w_rise_stop)                                 w_next = ST_IDLE;
                else if (w_rise_snooze && (r_snooze_left != 4'd0)) w_next = ST_SNOOZE;
                else if (w_ring_done)                            w_next = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (w_rise_stop)        w_next = ST_IDLE;
                else if (w_snooze_done) w_next = ST_RING;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_state_change = (w_next != r_state);

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_prescaler (
        .i_clk     (CLK),
        .i_rst_n   (RESETN),
        .i_clr     (w_state_change),
        .o_sec_tick(w_sec_tick)
    );

    // Edge-detect history resets high so a level already asserted at reset
    // release is not mistaken for a fresh press or trigger.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_alarm_d  <= 1'b1;
            r_stop_d   <= 1'b1;
            r_snooze_d <= 1'b1;
        end else begin
            r_alarm_d  <= ALARM_DOING;
            r_stop_d   <= KEY_STOP;
            r_snooze_d <= KEY_SNOOZE;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state         <= ST_IDLE;
            r_sec           <= '0;
            r_cad_cnt       <= '0;
            r_cad_on        <= 1'b0;
            r_tone_cnt      <= '0;
            r_piezo         <= 1'b0;
            r_ring_led      <= 1'b0;
            r_snooze_active <= 1'b0;
            r_snooze_left   <= 4'(MAX_SNOOZE);
        end else begin
            r_state         <= w_next;
            r_ring_led      <= (w_next == ST_RING);
            r_snooze_active <= (w_next == ST_SNOOZE);

            if (w_state_change) begin
                // Every entry starts fresh timers; entering RING begins an
                // on-phase with the tone high.
                r_sec      <= '0;
                r_cad_cnt  <= '0;
                r_tone_cnt <= '0;
                r_cad_on   <= (w_next == ST_RING);
                r_piezo    <= (w_next == ST_RING);
                if (w_next == ST_IDLE) begin
                    r_snooze_left <= 4'(MAX_SNOOZE);
                end else if (w_next == ST_SNOOZE) begin
                    r_snooze_left <= r_snooze_left - 4'd1;
                end
            end else if (r_state == ST_RING) begin
                if (w_sec_tick) r_sec <= r_sec + 1'b1;
                if (r_cad_cnt == CAD_W'(CADENCE_CYC - 1)) begin
                    // Phase boundary: the new phase's tone level is its
                    // on/off flag, and the tone counter restarts.
                    r_cad_cnt  <= '0;
                    r_cad_on   <= ~r_cad_on;
                    r_tone_cnt <= '0;
                    r_piezo    <= ~r_cad_on;
                end else begin
                    r_cad_cnt <= r_cad_cnt + 1'b1;
                    if (r_cad_on) begin
                        if (r_tone_cnt == TONE_W'(TONE_HALF - 1)) begin
                            r_tone_cnt <= '0;
                            r_piezo    <= ~r_piezo;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + 1'b1;
                        end
                    end else begin
                        r_tone_cnt <= '0;
                        r_piezo    <= 1'b0;
                    end
                end
            end else if (r_state == ST_SNOOZE) begin
                if (w_sec_tick) r_sec <= r_sec + 1'b1;
                r_piezo <= 1'b0;
            end else begin
                r_piezo <= 1'b0;
            end
        end
    end

    assign PIEZO         = r_piezo;
    assign RING_LED      = r_ring_led;
    assign SNOOZE_ACTIVE = r_snooze_active;
    assign SNOOZE_LEFT   = r_snooze_left;

endmodule
